// File: rtl/serial_adder_n_if.sv
// Operand/result bundle for serial_adder_n.
// Handshake: Start is a request with no ready line; it is accepted on a rising
// edge only while the block is idle (Busy=0 and Done=0), and A/B/Sub are
// captured on that same edge. Done is a one-cycle pulse marking S/Co/Ov valid.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             Ov;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Sub, A, B,
    input  S, Co, Ov, Busy, Done
  );

  modport slave (
    input  Start, Sub, A, B,
    output S, Co, Ov, Busy, Done
  );
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full adder processes one bit per clock,
// LSB first, taking WIDTH cycles per operation plus one Done cycle.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  serial_adder_n_if.slave        bus,
  output logic [1:0]             dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_out;

  assign dbg_state = state;

  always_comb begin
    sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    carry_out = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.S    <= '0;
      bus.Co   <= 1'b0;
      bus.Ov   <= 1'b0;
      bus.Busy <= 1'b0;
      bus.Done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.Done <= 1'b0;
          if (bus.Start) begin
            // Subtraction is A + ~B + 1: invert B and preload the carry with 1.
            a_sh     <= bus.A;
            b_sh     <= bus.Sub ? ~bus.B : bus.B;
            carry    <= bus.Sub;
            cnt      <= '0;
            state    <= RUN;
            bus.Busy <= 1'b1;
          end
        end
        RUN: begin
          acc   <= {sum_bit, acc[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= carry_out;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            // On the MSB step, carry holds the carry into the MSB.
            bus.S    <= {sum_bit, acc[WIDTH-1:1]};
            bus.Co   <= carry_out;
            bus.Ov   <= carry ^ carry_out;
            bus.Busy <= 1'b0;
            bus.Done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.Done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.Busy <= 1'b0;
          bus.Done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n: WIDTH=8 directed/random cases and
// an exhaustive WIDTH=4 sweep, scored against a whole-word arithmetic model.
module tb_serial_adder_n;
  logic       CLK;
  logic       rst_n8;
  logic       rst_n4;
  logic [1:0] dbg8;
  logic [1:0] dbg4;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q8[$];
  logic [31:0] exp_q4[$];
  logic [7:0]  last_s8;

  serial_adder_n_if #(.WIDTH(8)) d8 ();
  serial_adder_n_if #(.WIDTH(4)) d4 ();

  serial_adder_n #(.WIDTH(8)) dut8 (.CLK(CLK), .RST_N(rst_n8), .bus(d8.slave), .dbg_state(dbg8));
  serial_adder_n #(.WIDTH(4)) dut4 (.CLK(CLK), .RST_N(rst_n4), .bus(d4.slave), .dbg_state(dbg4));

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {ov, co, s} packed from bit 0 upward, s occupying w bits.
  function automatic logic [31:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic sub);
    logic [63:0] mask, bb, full, s;
    logic co, ov;
    mask = (64'd1 << w) - 64'd1;
    bb   = sub ? ((~{32'd0, b}) & mask) : ({32'd0, b} & mask);
    full = ({32'd0, a} & mask) + bb + {63'd0, sub};
    s    = full & mask;
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return s[31:0] | (32'(co) << w) | (32'(ov) << (w + 1));
  endfunction

  // ---------------- scoreboards ----------------
  always @(negedge CLK) begin : mon8
    logic [31:0] e;
    if (rst_n8 && d8.Done) begin
      if (exp_q8.size() == 0) begin
        check("spurious_done8", 32'(d8.Done), 32'd0);
      end else begin
        e = exp_q8.pop_front();
        check("s8", 32'(d8.S), 32'(e[7:0]));
        check("co8", 32'(d8.Co), 32'(e[8]));
        check("ov8", 32'(d8.Ov), 32'(e[9]));
        check("busy_in_done8", 32'(d8.Busy), 32'd0);
      end
    end
  end

  always @(negedge CLK) begin : mon4
    logic [31:0] e;
    if (rst_n4 && d4.Done) begin
      if (exp_q4.size() == 0) begin
        check("spurious_done4", 32'(d4.Done), 32'd0);
      end else begin
        e = exp_q4.pop_front();
        check("s4", 32'(d4.S), 32'(e[3:0]));
        check("co4", 32'(d4.Co), 32'(e[4]));
        check("ov4", 32'(d4.Ov), 32'(e[5]));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub, input bit glitch);
    int busy_n, lat;
    bit seen;
    logic [31:0] e;
    @(negedge CLK);
    d8.Start = 1'b1; d8.A = a; d8.B = b; d8.Sub = sub;
    e = model(8, 32'(a), 32'(b), sub);
    exp_q8.push_back(e);
    @(posedge CLK); #1;
    d8.Start = 1'b0;
    busy_n = 0; lat = 0; seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge CLK);
      if (glitch && i == 3) begin
        d8.Start = 1'b1; d8.A = ~a; d8.B = 8'h5A; d8.Sub = ~sub;
      end
      if (glitch && i == 4) d8.Start = 1'b0;
      if (d8.Busy) begin
        busy_n++;
        if (i == 2) check("s_hold_run", 32'(d8.S), 32'(last_s8));
      end
      if (d8.Done) begin
        seen = 1'b1;
        lat  = i - 1;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("done_latency", 32'(lat), 32'd8);
    check("busy_cycles", 32'(busy_n), 32'd8);
    last_s8 = e[7:0];
  endtask

  task automatic abort8(input logic [7:0] a, input logic [7:0] b);
    @(negedge CLK);
    d8.Start = 1'b1; d8.A = a; d8.B = b; d8.Sub = 1'b0;
    exp_q8.push_back(model(8, 32'(a), 32'(b), 1'b0));
    @(posedge CLK); #1;
    d8.Start = 1'b0;
    repeat (4) @(negedge CLK);
    rst_n8 = 1'b0;
    exp_q8.delete();
    @(negedge CLK);
    check("abort_busy", 32'(d8.Busy), 32'd0);
    check("abort_done", 32'(d8.Done), 32'd0);
    check("abort_s", 32'(d8.S), 32'd0);
    check("abort_co", 32'(d8.Co), 32'd0);
    check("abort_state", 32'(dbg8), 32'd0);
    rst_n8 = 1'b1;
    last_s8 = 8'h00;
    repeat (12) @(negedge CLK);
  endtask

  task automatic hold8();
    logic [7:0] a, b;
    int t[3];
    int n;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    for (int k = 0; k < 3; k++) exp_q8.push_back(model(8, 32'(a), 32'(b), 1'b0));
    @(negedge CLK);
    d8.Start = 1'b1; d8.A = a; d8.B = b; d8.Sub = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge CLK);
      if (d8.Done) begin
        t[n] = i;
        n++;
        if (n == 3) d8.Start = 1'b0;
      end
    end
    d8.Start = 1'b0;
    check("hold_done_count", 32'(n), 32'd3);
    if (n == 3) begin
      check("hold_period_1", 32'(t[1] - t[0]), 32'd10);
      check("hold_period_2", 32'(t[2] - t[1]), 32'd10);
    end
    last_s8 = a + b;
    repeat (2) @(negedge CLK);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sub);
    bit seen;
    @(negedge CLK);
    d4.Start = 1'b1; d4.A = a; d4.B = b; d4.Sub = sub;
    exp_q4.push_back(model(4, 32'(a), 32'(b), sub));
    @(posedge CLK); #1;
    d4.Start = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge CLK);
      if (d4.Done) seen = 1'b1;
    end
    if (!seen) check("done4_timeout", 32'(seen), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n8 = 1'b0; rst_n4 = 1'b0;
    d8.Start = 1'b1; d8.Sub = 1'b0; d8.A = 8'h11; d8.B = 8'h22;
    d4.Start = 1'b0; d4.Sub = 1'b0; d4.A = '0; d4.B = '0;
    last_s8 = 8'h00;
    repeat (3) @(negedge CLK);
    // Start is held high through reset; reset must win.
    check("rst_state8", 32'(dbg8), 32'd0);
    check("rst_busy8", 32'(d8.Busy), 32'd0);
    check("rst_done8", 32'(d8.Done), 32'd0);
    check("rst_s8", 32'(d8.S), 32'd0);
    check("rst_co8", 32'(d8.Co), 32'd0);
    check("rst_ov8", 32'(d8.Ov), 32'd0);
    check("rst_state4", 32'(dbg4), 32'd0);
    d8.Start = 1'b0;
    rst_n8 = 1'b1; rst_n4 = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_s_hold", 32'(d8.S), 32'd0);

    op8(8'h3C, 8'h0F, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0);
    op8(8'h05, 8'h07, 1'b1, 1'b0);
    op8(8'h80, 8'h01, 1'b1, 1'b0);
    abort8(8'h12, 8'h34);
    op8(8'h02, 8'h03, 1'b0, 1'b0);
    op8(8'h21, 8'h43, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++)
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    hold8();

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int s = 0; s < 2; s++)
          op4(4'(a), 4'(b), 1'(s));

    repeat (3) @(negedge CLK);
    check("q8_drained", 32'(exp_q8.size()), 32'd0);
    check("q4_drained", 32'(exp_q4.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
